multicycle_control_unit: RTL

- Moore FSM controller that drives every control input of the multicycle processor datapath.
- Consumes the datapath's IR output.
- Sequences fetch, decode, execute, memory and writeback/PC-update steps.
- Sits beside the datapath in the processor top; together they form the complete CPU.

---
 rtl/mcu_pkg.sv | 65 ++++++
 rtl/mcu_decode.sv | 54 +++++
 rtl/multicycle_control_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared types and constants for the multicycle processor control unit.
// Opcode classes come from IR[31:29]; ctrl_t bundles every registered control output.
package mcu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WBPC,
        HALTED
    } state_t;

    localparam logic [2:0] CLS_ALU  = 3'b000;
    localparam logic [2:0] CLS_ALUI = 3'b001;
    localparam logic [2:0] CLS_LD   = 3'b010;
    localparam logic [2:0] CLS_ST   = 3'b011;
    localparam logic [2:0] CLS_BR   = 3'b100;
    localparam logic [2:0] CLS_JMP  = 3'b101;
    localparam logic [2:0] CLS_RET  = 3'b110;
    localparam logic [2:0] CLS_HALT = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    localparam logic [1:0] REL_ZERO     = 2'b00;
    localparam logic [1:0] REL_POSITIVE = 2'b01;
    localparam logic [1:0] REL_NEGATIVE = 2'b10;
    localparam logic [1:0] REL_ALWAYS   = 2'b11;

    // One bit per func code; set bits are reg-reg funcs 0,2,4,6,8,11,13,15.
    localparam logic [31:0] REG_REG_FUNCS = 32'h0000_A955;

    function automatic logic is_reg_reg(input logic [4:0] func);
        return REG_REG_FUNCS[func];
    endfunction

    typedef struct packed {
        logic       load_pc;
        logic       load_npc;
        logic       read_im;
        logic       load_ir;
        logic       read_reg_port1;
        logic       read_reg_port2;
        logic       load_a;
        logic       load_b;
        logic       load_imm;
        logic       load_imm1;
        logic       mux_alu1;
        logic       mux_alu2;
        logic       mux_imm;
        logic [3:0] alu_func;
        logic       load_alu_out;
        logic       read_dm;
        logic       write_dm;
        logic       load_lmd;
        logic       mux_dm;
        logic       mux_wb;
        logic       write_reg;
        logic       mux_pc;
        logic       mux_ret;
        logic [1:0] mux_rel;
        logic       halt;
    } ctrl_t;

endpackage

// File: rtl/mcu_decode.sv
// Combinational instruction decoder: turns IR into class flags, ALU function
// and branch condition select.
import mcu_pkg::*;

module mcu_decode (
    input  logic [31:0] ir,
    output logic        is_alu,
    output logic        use_imm,
    output logic        is_ld,
    output logic        is_st,
    output logic        is_br,
    output logic        is_jmp,
    output logic        is_ret,
    output logic        is_halt,
    output logic        st_npc,
    output logic [3:0]  alu_func,
    output logic [1:0]  mux_rel
);

    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[28:23], ir[20:5]};

    always_comb begin
        is_alu  = 1'b0;
        use_imm = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_br   = 1'b0;
        is_jmp  = 1'b0;
        is_ret  = 1'b0;
        is_halt = 1'b0;
        unique case (ir[31:29])
            CLS_ALU: begin
                is_alu  = 1'b1;
                use_imm = !is_reg_reg(ir[4:0]);
            end
            CLS_ALUI: begin
                is_alu  = 1'b1;
                use_imm = 1'b1;
            end
            CLS_LD:   is_ld   = 1'b1;
            CLS_ST:   is_st   = 1'b1;
            CLS_BR:   is_br   = 1'b1;
            CLS_JMP:  is_jmp  = 1'b1;
            CLS_RET:  is_ret  = 1'b1;
            CLS_HALT: is_halt = 1'b1;
            default:  is_halt = 1'b0;
        endcase
        alu_func = is_alu ? ir[3:0] : ALU_ADD;
        mux_rel  = ir[22:21];
        st_npc   = ir[0];
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore controller for the multicycle datapath. Every output is registered and
// reflects the state being entered on that clock edge.
import mcu_pkg::*;

module multicycle_control_unit #(
    parameter int RET_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          IR,
    output logic                 loadPC,
    output logic                 loadNPC,
    output logic                 readIM,
    output logic                 loadIR,
    output logic                 readRegPort1,
    output logic                 readRegPort2,
    output logic                 loadA,
    output logic                 loadB,
    output logic                 loadIMM,
    output logic                 loadIMM1,
    output logic                 muxALU1,
    output logic                 muxALU2,
    output logic                 muxIMM,
    output logic [3:0]           ALUfunc,
    output logic                 loadALUout,
    output logic                 readDM,
    output logic                 writeDM,
    output logic                 loadLMD,
    output logic                 muxDM,
    output logic                 muxWB,
    output logic                 writeReg,
    output logic                 muxPC,
    output logic                 muxRET,
    output logic [1:0]           muxREL,
    output logic                 HALT,
    output logic [RET_WIDTH-1:0] retired
);

    state_t               state_q, state_d;
    ctrl_t                ctrl_q, ctrl_d;
    logic [RET_WIDTH-1:0] retired_q, retired_d;
    logic                 started_q, started_d;

    logic       is_alu, use_imm, is_ld, is_st, is_br, is_jmp, is_ret, is_halt, st_npc;
    logic [3:0] dec_alu_func;
    logic [1:0] dec_mux_rel;

    mcu_decode u_decode (
        .ir       (IR),
        .is_alu   (is_alu),
        .use_imm  (use_imm),
        .is_ld    (is_ld),
        .is_st    (is_st),
        .is_br    (is_br),
        .is_jmp   (is_jmp),
        .is_ret   (is_ret),
        .is_halt  (is_halt),
        .st_npc   (st_npc),
        .alu_func (dec_alu_func),
        .mux_rel  (dec_mux_rel)
    );

    // After reset the machine sits in FETCH with outputs cleared, so the first
    // edge without reset re-enters FETCH to drive its pulses.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = '0;
        retired_d = retired_q;
        started_d = 1'b1;

        if (!started_q) begin
            state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH:   state_d = DECODE;
                DECODE:  state_d = is_halt ? HALTED : EXEC;
                EXEC:    state_d = (is_ld || is_st || is_ret) ? MEM : WBPC;
                MEM:     state_d = WBPC;
                WBPC:    state_d = FETCH;
                HALTED:  state_d = HALTED;
                default: state_d = FETCH;
            endcase
        end

        unique case (state_d)
            FETCH: begin
                ctrl_d.read_im  = 1'b1;
                ctrl_d.load_ir  = 1'b1;
                ctrl_d.load_npc = 1'b1;
            end
            DECODE: begin
                ctrl_d.read_reg_port1 = 1'b1;
                ctrl_d.read_reg_port2 = 1'b1;
                ctrl_d.load_a         = 1'b1;
                ctrl_d.load_b         = 1'b1;
                ctrl_d.load_imm       = 1'b1;
                ctrl_d.load_imm1      = 1'b1;
            end
            EXEC: begin
                ctrl_d.load_alu_out = 1'b1;
                ctrl_d.alu_func     = dec_alu_func;
                if (is_alu) begin
                    ctrl_d.mux_alu2 = use_imm;
                end else if (is_br) begin
                    ctrl_d.mux_alu1 = 1'b1;
                    ctrl_d.mux_alu2 = 1'b1;
                end else if (is_jmp) begin
                    ctrl_d.mux_alu1 = 1'b1;
                    ctrl_d.mux_alu2 = 1'b1;
                    ctrl_d.mux_imm  = 1'b1;
                end else begin
                    ctrl_d.mux_alu2 = 1'b1;
                end
            end
            MEM: begin
                if (is_st) begin
                    ctrl_d.write_dm = 1'b1;
                    ctrl_d.mux_dm   = st_npc;
                end else begin
                    ctrl_d.read_dm  = 1'b1;
                    ctrl_d.load_lmd = 1'b1;
                end
            end
            WBPC: begin
                ctrl_d.load_pc = 1'b1;
                retired_d      = retired_q + RET_WIDTH'(1);
                if (is_alu) begin
                    ctrl_d.write_reg = 1'b1;
                    ctrl_d.mux_wb    = 1'b1;
                end else if (is_ld) begin
                    ctrl_d.write_reg = 1'b1;
                end else if (is_br) begin
                    ctrl_d.mux_pc  = 1'b1;
                    ctrl_d.mux_rel = dec_mux_rel;
                end else if (is_jmp) begin
                    ctrl_d.mux_pc  = 1'b1;
                    ctrl_d.mux_rel = REL_ALWAYS;
                end else if (is_ret) begin
                    ctrl_d.mux_ret = 1'b1;
                end
            end
            HALTED:  ctrl_d.halt = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            ctrl_q    <= '0;
            retired_q <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            retired_q <= retired_d;
            started_q <= started_d;
        end
    end

    assign loadPC       = ctrl_q.load_pc;
    assign loadNPC      = ctrl_q.load_npc;
    assign readIM       = ctrl_q.read_im;
    assign loadIR       = ctrl_q.load_ir;
    assign readRegPort1 = ctrl_q.read_reg_port1;
    assign readRegPort2 = ctrl_q.read_reg_port2;
    assign loadA        = ctrl_q.load_a;
    assign loadB        = ctrl_q.load_b;
    assign loadIMM      = ctrl_q.load_imm;
    assign loadIMM1     = ctrl_q.load_imm1;
    assign muxALU1      = ctrl_q.mux_alu1;
    assign muxALU2      = ctrl_q.mux_alu2;
    assign muxIMM       = ctrl_q.mux_imm;
    assign ALUfunc      = ctrl_q.alu_func;
    assign loadALUout   = ctrl_q.load_alu_out;
    assign readDM       = ctrl_q.read_dm;
    assign writeDM      = ctrl_q.write_dm;
    assign loadLMD      = ctrl_q.load_lmd;
    assign muxDM        = ctrl_q.mux_dm;
    assign muxWB        = ctrl_q.mux_wb;
    assign writeReg     = ctrl_q.write_reg;
    assign muxPC        = ctrl_q.mux_pc;
    assign muxRET       = ctrl_q.mux_ret;
    assign muxREL       = ctrl_q.mux_rel;
    assign HALT         = ctrl_q.halt;
    assign retired      = retired_q;

endmodule
